// File: rtl/pmod_i2s_rx.sv
// I2S slave receiver: oversamples SCLK/LRCLK/SDOUT in the clk domain and emits
// each complete left/right frame as a word pair with a one-cycle valid strobe.
module pmod_i2s_rx #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i2s_en,
   input  logic              i2s_sclk,
   input  logic              i2s_lrclk,
   input  logic              i2s_sdout,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              sample_valid,
   output logic              frame_err
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] FULL = CW'(DATA_W);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        pin_s1, pin_s2;
   logic              sclk_d;
   logic              lr_prev_reg, lr_prev_next;
   logic              slot_reg, slot_next;
   logic [CW-1:0]     cnt_reg, cnt_next;
   logic [DATA_W-1:0] shreg_reg, shreg_next;
   logic [DATA_W-1:0] hold_reg, hold_next;
   logic              ok_reg, ok_next;
   logic [DATA_W-1:0] left_next, right_next;
   logic              valid_next, err_next;

   logic              sclk_s2, lr_s2, sd_s2, rise, chg;
   logic [DATA_W-1:0] word;
   logic [CW-1:0]     n;

   assign sclk_s2 = pin_s2[2];
   assign lr_s2   = pin_s2[1];
   assign sd_s2   = pin_s2[0];
   assign rise    = sclk_s2 & ~sclk_d;
   assign chg     = lr_s2 != lr_prev_reg;

   // Identical two-flop synchronisers for all three pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pin_s1 <= '0;
         pin_s2 <= '0;
         sclk_d <= 1'b0;
      end else begin
         pin_s1 <= {i2s_sclk, i2s_lrclk, i2s_sdout};
         pin_s2 <= pin_s1;
         sclk_d <= sclk_s2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         lr_prev_reg  <= 1'b0;
         slot_reg     <= 1'b0;
         cnt_reg      <= '0;
         shreg_reg    <= '0;
         hold_reg     <= '0;
         ok_reg       <= 1'b0;
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lr_prev_reg  <= lr_prev_next;
         slot_reg     <= slot_next;
         cnt_reg      <= cnt_next;
         shreg_reg    <= shreg_next;
         hold_reg     <= hold_next;
         ok_reg       <= ok_next;
         left_data    <= left_next;
         right_data   <= right_next;
         sample_valid <= valid_next;
         frame_err    <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      lr_prev_next = lr_prev_reg;
      slot_next    = slot_reg;
      cnt_next     = cnt_reg;
      shreg_next   = shreg_reg;
      hold_next    = hold_reg;
      ok_next      = ok_reg;
      left_next    = left_data;
      right_next   = right_data;
      valid_next   = 1'b0;
      err_next     = 1'b0;

      // Bits past DATA_W are dropped so long slots keep only their MSBs.
      word = shreg_reg;
      n    = cnt_reg;
      if (cnt_reg < FULL) begin
         word = {shreg_reg[DATA_W-2:0], sd_s2};
         n    = cnt_reg + CW'(1);
      end

      // lr_prev tracks LRCLK even while disabled so re-enable resyncs cleanly.
      if (rise)
         lr_prev_next = lr_s2;

      if (!i2s_en) begin
         state_next = IDLE;
         cnt_next   = '0;
         ok_next    = 1'b0;
      end else if (rise) begin
         case (state_reg)
            IDLE: begin
               if (chg) begin
                  slot_next  = lr_s2;
                  cnt_next   = '0;
                  ok_next    = 1'b0;
                  state_next = SHIFT;
               end
            end
            SHIFT: begin
               shreg_next = word;
               cnt_next   = n;
               // With the one-bit I2S delay, the bit on an LRCLK change closes the old slot.
               if (chg) begin
                  if (n == FULL) begin
                     if (!slot_reg) begin
                        hold_next = word;
                        ok_next   = 1'b1;
                     end else if (ok_reg) begin
                        left_next  = hold_reg;
                        right_next = word;
                        valid_next = 1'b1;
                        ok_next    = 1'b0;
                     end
                  end else begin
                     err_next = 1'b1;
                     ok_next  = 1'b0;
                  end
                  slot_next = lr_s2;
                  cnt_next  = '0;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pmod_i2s_rx.sv
// Scoreboard bench for pmod_i2s_rx: a behavioural I2S master drives directed
// frames, expected pulses are queued, and a monitor checks each DUT strobe.
module tb_pmod_i2s_rx;

   typedef struct packed {
      logic        err;
      logic [15:0] l;
      logic [15:0] r;
   } exp_t;

   logic        clk, rst, i2s_en, i2s_sclk, i2s_lrclk, i2s_sdout;
   logic [15:0] left_data, right_data;
   logic        sample_valid, frame_err;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   logic carry;
   time  rise_t;

   pmod_i2s_rx #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst), .i2s_en(i2s_en),
      .i2s_sclk(i2s_sclk), .i2s_lrclk(i2s_lrclk), .i2s_sdout(i2s_sdout),
      .left_data(left_data), .right_data(right_data),
      .sample_valid(sample_valid), .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end else
         $display("[TB] ok %s = %0h", name, got);
   endtask

   task automatic chk_rng(input string name, input int got, input int lo, input int hi);
      tests++;
      if (got < lo || got > hi) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end else
         $display("[TB] ok %s = %0d", name, got);
   endtask

   // Sends SCLK periods start..start+cnt-1 of a slot; period 0 carries the previous slot's LSB.
   task automatic send_bits(input logic lr, input logic [31:0] w, input int len,
                            input int start, input int cnt);
      for (int i = start; i < start + cnt; i++) begin
         i2s_sclk  = 1'b0;
         i2s_lrclk = lr;
         i2s_sdout = (i == 0) ? carry : w[len - i];
         #160;
         i2s_sclk = 1'b1;
         rise_t   = $time;
         #160;
      end
      if (start + cnt == len)
         carry = w[0];
   endtask

   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int len);
      send_bits(1'b0, l, len, 0, len);
      send_bits(1'b1, r, len, 0, len);
   endtask

   task automatic push(input logic err, input logic [15:0] l, input logic [15:0] r);
      exp_t e;
      e.err = err;
      e.l   = l;
      e.r   = r;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst && (sample_valid || frame_err)) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none",
                     sample_valid, frame_err);
         end else begin
            e = q.pop_front();
            chk("pulse_is_err", 32'(frame_err), 32'(e.err));
            if (!e.err) begin
               chk("left_word", 32'(left_data), 32'(e.l));
               chk("right_word", 32'(right_data), 32'(e.r));
               chk_rng("valid_latency_ns", int'($time - rise_t), 25, 45);
            end
         end
      end
   end

   initial begin
      rst       = 1'b0;
      i2s_en    = 1'b1;
      i2s_sclk  = 1'b0;
      i2s_lrclk = 1'b0;
      i2s_sdout = 1'b0;
      carry     = 1'b0;
      rise_t    = 0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_left", 32'(left_data), 32'h0);
      chk("rst_right", 32'(right_data), 32'h0);
      chk("rst_valid", 32'(sample_valid), 32'h0);
      chk("rst_err", 32'(frame_err), 32'h0);
      rst = 1'b1;

      // Start mid left slot; that partial slot and the next right slot give no pulse.
      send_bits(1'b0, 32'h0000, 16, 9, 7);
      send_bits(1'b1, 32'h5555, 16, 0, 16);
      push(1'b0, 16'hA5C3, 16'h1234);
      send_frame(32'hA5C3, 32'h1234, 16);

      // 32-bit slots keep the upper 16 bits.
      push(1'b0, 16'h1234, 16'hFEDC);
      send_frame(32'h12345678, 32'hFEDCBA98, 32);

      // 8-bit slots: every slot end is a framing error.
      repeat (4) push(1'b1, 16'h0, 16'h0);
      send_frame(32'h5A, 32'hC3, 8);
      send_frame(32'h81, 32'h7E, 8);
      chk("short_hold_left", 32'(left_data), 32'h1234);
      chk("short_hold_right", 32'(right_data), 32'hFEDC);
      push(1'b0, 16'hBEEF, 16'hCAFE);
      send_frame(32'hBEEF, 32'hCAFE, 16);

      // Disable for three frames after the BEEF/CAFE pair completes.
      send_bits(1'b0, 32'h1111, 16, 0, 1);
      i2s_en = 1'b0;
      send_bits(1'b0, 32'h1111, 16, 1, 15);
      send_bits(1'b1, 32'h2222, 16, 0, 16);
      send_frame(32'h3333, 32'h4444, 16);
      send_frame(32'h5555, 32'h6666, 16);
      chk("dis_hold_left", 32'(left_data), 32'hBEEF);
      chk("dis_hold_right", 32'(right_data), 32'hCAFE);
      i2s_en = 1'b1;
      push(1'b0, 16'h7777, 16'h8888);
      send_frame(32'h7777, 32'h8888, 16);

      // Reset after 5 bits of a left slot.
      send_bits(1'b0, 32'h9999, 16, 0, 5);
      rst = 1'b0;
      #1;
      chk("midrst_left", 32'(left_data), 32'h0);
      chk("midrst_right", 32'(right_data), 32'h0);
      chk("midrst_valid", 32'(sample_valid), 32'h0);
      chk("midrst_err", 32'(frame_err), 32'h0);
      #49;
      rst = 1'b1;
      send_bits(1'b0, 32'h9999, 16, 5, 11);
      send_bits(1'b1, 32'hAAAA, 16, 0, 16);
      push(1'b0, 16'hC3A5, 16'h0FF0);
      send_frame(32'hC3A5, 32'h0FF0, 16);
      send_bits(1'b0, 32'h0000, 16, 0, 2);

      for (int k = 0; k < 200 && q.size() != 0; k++)
         @(posedge clk);
      chk("queue_drained", 32'(q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
